// File: rtl/pixie_pkg.sv
// Constants and types shared by the Pixie DMA front end and the video back end.
// The frame buffer is 128 lines x 8 bytes, addressed as {line[6:0], byte[2:0]}.
package pixie_pkg;

  localparam int PIXIE_H_TOTAL        = 112;
  localparam int PIXIE_V_TOTAL        = 262;
  localparam int PIXIE_V_ACT          = 80;
  localparam int PIXIE_BYTES_PER_LINE = 8;
  localparam int PIXIE_LINES          = 128;
  localparam int PIXIE_FB_AW          = 10;
  localparam int PIXIE_H_PIXELS       = PIXIE_BYTES_PER_LINE * 8;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
  } pixie_sync_t;

  localparam pixie_sync_t PIXIE_SYNC_RESET = '{hsync: 1'b0, vsync: 1'b0, hblank: 1'b1, vblank: 1'b1};

  // True when lo <= x < lo + len.
  function automatic logic in_window(input int x, input int lo, input int len);
    return (x >= lo) && (x < lo + len);
  endfunction

endpackage

// File: rtl/pixie_video_back_end_if.sv
// Frame-buffer read port plus the video output bundle of the Pixie back end.
// fb_data is a plain synchronous read: it reflects fb_addr one clk later, no handshake.
interface pixie_video_back_end_if;

  logic [pixie_pkg::PIXIE_FB_AW-1:0] fb_addr;
  logic [7:0]                        fb_data;
  logic                              pixel;
  logic                              hsync;
  logic                              vsync;
  logic                              hblank;
  logic                              vblank;
  logic                              de;

  modport master (
    output fb_addr, pixel, hsync, vsync, hblank, vblank, de,
    input  fb_data
  );

  modport slave (
    input  fb_addr, pixel, hsync, vsync, hblank, vblank, de,
    output fb_data
  );

endinterface

// File: rtl/pixie_video_timing.sv
// CDP1861-style raster counters with registered sync/blank decode.
// Outputs decode the pre-increment counter value, so they lag the counters by one ce.
module pixie_video_timing
  import pixie_pkg::*;
#(
  parameter int H_TOTAL  = PIXIE_H_TOTAL,
  parameter int V_TOTAL  = PIXIE_V_TOTAL,
  parameter int H_ACT    = 32,
  parameter int V_ACT    = PIXIE_V_ACT,
  parameter int HS_START = 100,
  parameter int HS_LEN   = 8,
  parameter int VS_START = 0,
  parameter int VS_LEN   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ce,
  output logic [6:0]  o_h_cnt,
  output logic [8:0]  o_v_cnt,
  output pixie_sync_t o_sync
);

  logic [6:0]  r_h_cnt;
  logic [8:0]  r_v_cnt;
  pixie_sync_t r_sync;
  pixie_sync_t w_sync;
  logic        w_h_wrap;
  logic        w_v_wrap;

  assign w_h_wrap = (int'(r_h_cnt) == H_TOTAL - 1);
  assign w_v_wrap = (int'(r_v_cnt) == V_TOTAL - 1);

  always_comb begin
    w_sync        = PIXIE_SYNC_RESET;
    w_sync.hblank = !in_window(int'(r_h_cnt), H_ACT, PIXIE_H_PIXELS);
    w_sync.vblank = !in_window(int'(r_v_cnt), V_ACT, PIXIE_LINES);
    w_sync.hsync  = in_window(int'(r_h_cnt), HS_START, HS_LEN);
    w_sync.vsync  = in_window(int'(r_v_cnt), VS_START, VS_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_sync  <= PIXIE_SYNC_RESET;
    end else if (i_ce) begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 7'd1;
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 9'd1;
      end
      r_sync <= w_sync;
    end
  end

  assign o_h_cnt = r_h_cnt;
  assign o_v_cnt = r_v_cnt;
  assign o_sync  = r_sync;

endmodule

// File: rtl/pixie_video_back_end.sv
// Pixie video back end: raster timing plus the frame-buffer fetch / shift pipeline.
// Each active byte is addressed 2 dots ahead and loaded 1 dot ahead of its first pixel.
module pixie_video_back_end
  import pixie_pkg::*;
#(
  parameter int H_TOTAL  = PIXIE_H_TOTAL,
  parameter int V_TOTAL  = PIXIE_V_TOTAL,
  parameter int H_ACT    = 32,
  parameter int V_ACT    = PIXIE_V_ACT,
  parameter int HS_START = 100,
  parameter int HS_LEN   = 8,
  parameter int VS_START = 0,
  parameter int VS_LEN   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_pix,
  input  logic                   disp_en,
  pixie_video_back_end_if.master vid
);

  localparam logic [6:0] LP_ADDR_H = 7'(H_ACT - 2);
  localparam logic [6:0] LP_LOAD_H = 7'(H_ACT - 1);
  localparam logic [6:0] LP_V_ACT7 = 7'(V_ACT);

  logic [6:0]  w_h_cnt;
  logic [8:0]  w_v_cnt;
  pixie_sync_t w_sync;

  pixie_video_timing #(
    .H_TOTAL (H_TOTAL),  .V_TOTAL (V_TOTAL),
    .H_ACT   (H_ACT),    .V_ACT   (V_ACT),
    .HS_START(HS_START), .HS_LEN  (HS_LEN),
    .VS_START(VS_START), .VS_LEN  (VS_LEN)
  ) u_timing (
    .clk    (clk),
    .rst_n  (reset),
    .i_ce   (ce_pix),
    .o_h_cnt(w_h_cnt),
    .o_v_cnt(w_v_cnt),
    .o_sync (w_sync)
  );

  logic [PIXIE_FB_AW-1:0] r_fb_addr;
  logic [7:0]             r_shreg;
  logic                   r_pixel;
  logic                   r_frame_en;

  logic       w_act_line;
  logic       w_act_dot;
  logic       w_addr_pt;
  logic       w_load_pt;
  logic       w_frame_start;
  logic [5:0] w_addr_off;
  logic [2:0] w_load_off;
  logic [6:0] w_line;

  assign w_act_line    = in_window(int'(w_v_cnt), V_ACT, PIXIE_LINES);
  assign w_act_dot     = w_act_line && in_window(int'(w_h_cnt), H_ACT, PIXIE_H_PIXELS);
  assign w_addr_off    = 6'(w_h_cnt - LP_ADDR_H);
  assign w_load_off    = 3'(w_h_cnt - LP_LOAD_H);
  assign w_line        = w_v_cnt[6:0] - LP_V_ACT7;
  assign w_frame_start = (w_h_cnt == '0) && (w_v_cnt == '0);

  // Fetch points repeat every 8 dots, starting 2 (address) and 1 (load) dots early.
  assign w_addr_pt = w_act_line && in_window(int'(w_h_cnt), H_ACT - 2, PIXIE_H_PIXELS)
                     && (w_addr_off[2:0] == 3'd0);
  assign w_load_pt = w_act_line && in_window(int'(w_h_cnt), H_ACT - 1, PIXIE_H_PIXELS)
                     && (w_load_off == 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fb_addr  <= '0;
      r_shreg    <= '0;
      r_pixel    <= 1'b0;
      r_frame_en <= 1'b0;
    end else if (ce_pix) begin
      // Latched once per frame so a mid-frame disp_en change cannot tear the picture.
      if (w_frame_start) begin
        r_frame_en <= disp_en;
      end
      if (w_addr_pt) begin
        r_fb_addr <= {w_line, w_addr_off[5:3]};
      end
      r_pixel <= w_act_dot & r_shreg[7] & r_frame_en;
      // The load for the next byte coincides with the last shift of the current one.
      if (w_load_pt) begin
        r_shreg <= vid.fb_data;
      end else if (w_act_dot) begin
        r_shreg <= {r_shreg[6:0], 1'b0};
      end
    end
  end

  assign vid.fb_addr = r_fb_addr;
  assign vid.pixel   = r_pixel;
  assign vid.hsync   = w_sync.hsync;
  assign vid.vsync   = w_sync.vsync;
  assign vid.hblank  = w_sync.hblank;
  assign vid.vblank  = w_sync.vblank;
  assign vid.de      = ~w_sync.hblank & ~w_sync.vblank;

  a_h_act_min: assert property (@(posedge clk) H_ACT >= 2)
    else $error("pixie_video_back_end: H_ACT below 2 leaves no room to fetch byte 0");

endmodule

// File: tb/tb_pixie_video_back_end.sv
// Directed bench for pixie_video_back_end: raster reference, hand-computed probe table,
// and sequences for disp_en toggling, ce_pix hold and asynchronous reset.
module tb_pixie_video_back_end;
  import pixie_pkg::*;

  typedef struct {
    int          frame;
    int          v;
    int          h;
    logic [15:0] exp;
    string       name;
  } probe_t;

  localparam int NPROBE = 21;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic ce_pix  = 1'b0;
  logic disp_en = 1'b0;

  pixie_video_back_end_if vid();

  pixie_video_back_end dut (
    .clk    (clk),
    .reset  (reset),
    .ce_pix (ce_pix),
    .disp_en(disp_en),
    .vid    (vid)
  );

  // ---------------- clock / frame-buffer memory ----------------
  always #5 clk = ~clk;

  logic [7:0] fb_mem [0:1023];
  always @(posedge clk) vid.fb_data <= fb_mem[vid.fb_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  int          tb_h, tb_v, frame;
  logic        exp_fen;
  logic [9:0]  exp_addr;
  probe_t      probes [NPROBE];
  int          probe_hits = 0;

  int          ce_idx = 0;
  int          vs_rise [2];
  int          hs_rise [2];
  int          n_vs_rise = 0, n_hs_rise = 0;
  logic        prev_vs = 1'b0, prev_hs = 1'b0;
  int          vs_hi_f0 = 0, de_f0 = 0, de_l80 = 0, lit_f0 = 0, bad_px = 0;
  logic [63:0] chk_line = '0;
  logic [7:0]  seq81 = '0;

  function automatic logic [15:0] mk(input int a, input bit px, input bit hs, input bit vs,
                                     input bit hb, input bit vb, input bit de);
    return {10'(a), px, hs, vs, hb, vb, de};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {vid.fb_addr, vid.pixel, vid.hsync, vid.vsync, vid.hblank, vid.vblank, vid.de};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic ce_tick();
    @(negedge clk) ce_pix = 1'b1;
    @(negedge clk) ce_pix = 1'b0;
  endtask

  // One dot: predict outputs for the current raster position, pulse ce, compare.
  task automatic step_ce();
    logic        hb, vb, hs, vs, de, px;
    logic [7:0]  byt;
    logic [15:0] got;
    int          l, k;
    if (tb_h == 0 && tb_v == 0) exp_fen = disp_en;
    hb = !(tb_h >= 32 && tb_h < 96);
    vb = !(tb_v >= 80 && tb_v < 208);
    hs = (tb_h >= 100 && tb_h < 108);
    vs = (tb_v < 4);
    de = !hb && !vb;
    l  = tb_v - 80;
    px = 1'b0;
    if (de) begin
      k   = (tb_h - 32) / 8;
      byt = fb_mem[l * 8 + k];
      px  = byt[7 - ((tb_h - 32) % 8)] & exp_fen;
    end
    if (!vb && tb_h >= 30 && tb_h <= 86 && ((tb_h - 30) % 8) == 0)
      exp_addr = 10'(l * 8 + (tb_h - 30) / 8);

    ce_tick();
    got = dut_vec();
    check($sformatf("raster f%0d v%0d h%0d", frame, tb_v, tb_h), 64'(got),
          64'({exp_addr, px, hs, vs, hb, vb, de}));
    foreach (probes[i]) begin
      if (probes[i].frame == frame && probes[i].v == tb_v && probes[i].h == tb_h) begin
        probe_hits++;
        check({"probe ", probes[i].name}, 64'(got), 64'(probes[i].exp));
      end
    end

    ce_idx++;
    if (got[3] && !prev_vs && n_vs_rise < 2) begin vs_rise[n_vs_rise] = ce_idx; n_vs_rise++; end
    if (got[4] && !prev_hs && n_hs_rise < 2) begin hs_rise[n_hs_rise] = ce_idx; n_hs_rise++; end
    prev_vs = got[3];
    prev_hs = got[4];
    if (frame == 0) begin
      vs_hi_f0 += int'(got[3]);
      de_f0    += int'(got[0]);
      lit_f0   += int'(got[5]);
      if (tb_v == 80) de_l80 += int'(got[0]);
    end
    if (got[5] && !got[0]) bad_px++;
    if (frame == 1 && tb_v == 105 && got[0]) chk_line = {chk_line[62:0], got[5]};
    if (frame == 1 && tb_v == 96 && tb_h >= 40 && tb_h <= 47) seq81 = {seq81[6:0], got[5]};

    tb_h++;
    if (tb_h == 112) begin
      tb_h = 0;
      tb_v++;
      if (tb_v == 262) begin
        tb_v = 0;
        frame++;
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [15:0] snap;

    probes[0]  = '{0,   0,   0, mk(0,    0, 0, 1, 1, 1, 0), "vsync_start"};
    probes[1]  = '{0,   0, 100, mk(0,    0, 1, 1, 1, 1, 0), "hsync_on"};
    probes[2]  = '{0,   0, 107, mk(0,    0, 1, 1, 1, 1, 0), "hsync_last"};
    probes[3]  = '{0,   0, 108, mk(0,    0, 0, 1, 1, 1, 0), "hsync_off"};
    probes[4]  = '{0,   4,   0, mk(0,    0, 0, 0, 1, 1, 0), "vsync_off"};
    probes[5]  = '{0,  80,  30, mk(0,    0, 0, 0, 1, 0, 0), "addr_l80_b0"};
    probes[6]  = '{0,  80,  32, mk(0,    0, 0, 0, 0, 0, 1), "first_dot_dark"};
    probes[7]  = '{0,  80,  38, mk(1,    0, 0, 0, 0, 0, 1), "addr_l80_b1"};
    probes[8]  = '{0,  80,  86, mk(7,    0, 0, 0, 0, 0, 1), "addr_l80_b7"};
    probes[9]  = '{0, 160,  32, mk(640,  0, 0, 0, 0, 0, 1), "dark_after_enable"};
    probes[10] = '{0, 207,  86, mk(1023, 0, 0, 0, 0, 0, 1), "addr_l207_b7"};
    probes[11] = '{0, 207,  95, mk(1023, 0, 0, 0, 0, 0, 1), "last_dot"};
    probes[12] = '{0, 207,  96, mk(1023, 0, 0, 0, 1, 0, 0), "hblank_after"};
    probes[13] = '{0, 208,  30, mk(1023, 0, 0, 0, 1, 1, 0), "no_fetch_inactive"};
    probes[14] = '{1,  81,  36, mk(8,    1, 0, 0, 0, 0, 1), "l81_b0_bit3"};
    probes[15] = '{1,  96,  40, mk(129,  1, 0, 0, 0, 0, 1), "byte81_bit7"};
    probes[16] = '{1,  96,  41, mk(129,  0, 0, 0, 0, 0, 1), "byte81_bit6"};
    probes[17] = '{1,  96,  47, mk(130,  1, 0, 0, 0, 0, 1), "byte81_bit0"};
    probes[18] = '{1, 105,  32, mk(200,  1, 0, 0, 0, 0, 1), "checker_first"};
    probes[19] = '{1, 105,  33, mk(200,  0, 0, 0, 0, 0, 1), "checker_second"};
    probes[20] = '{1, 110,  32, mk(240,  1, 0, 0, 0, 0, 1), "after_disable"};

    for (int i = 0; i < 1024; i++) fb_mem[i] = 8'(i);

    // Reset values while held in reset.
    reset   = 1'b0;
    disp_en = 1'b0;
    #12;
    check("reset_values", 64'(dut_vec()), 64'(mk(0, 0, 0, 0, 1, 1, 0)));
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    tb_h     = 0;
    tb_v     = 0;
    frame    = 0;
    exp_fen  = 1'b0;
    exp_addr = '0;

    // Frame 0 sampled disp_en=0; enable at line 150; frame 1 shows data; disable at line 100.
    while (!(frame == 1 && tb_v == 120 && tb_h == 50)) begin
      if (frame == 0 && tb_v == 150 && tb_h == 0) disp_en = 1'b1;
      if (frame == 1 && tb_v == 100 && tb_h == 0) disp_en = 1'b0;
      if (frame == 1 && tb_v == 101 && tb_h == 0)
        for (int i = 0; i < 1024; i++) fb_mem[i] = 8'hAA;
      if (frame == 1 && tb_v == 90 && tb_h == 60) begin
        snap = dut_vec();
        repeat (100) begin
          @(negedge clk);
          check("ce_hold_frozen", 64'(dut_vec()), 64'(snap));
        end
      end
      step_ce();
    end

    // Asynchronous reset at h=50, v=120 of an enabled, active line.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_reset_now", 64'(dut_vec()), 64'(mk(0, 0, 0, 0, 1, 1, 0)));
    ce_tick();
    check("reset_ignores_ce", 64'(dut_vec()), 64'(mk(0, 0, 0, 0, 1, 1, 0)));
    @(negedge clk) reset = 1'b1;
    tb_h     = 0;
    tb_v     = 0;
    frame    = 2;
    exp_addr = '0;
    repeat (2 * 112 + 20) step_ce();

    check("vsync_period",      64'(vs_rise[1] - vs_rise[0]), 64'(29344));
    check("hsync_period",      64'(hs_rise[1] - hs_rise[0]), 64'(112));
    check("vsync_len_f0",      64'(vs_hi_f0), 64'(4 * 112));
    check("de_per_line",       64'(de_l80), 64'(64));
    check("de_per_frame",      64'(de_f0), 64'(64 * 128));
    check("dark_frame_lit",    64'(lit_f0), 64'(0));
    check("pixel_outside_de",  64'(bad_px), 64'(0));
    check("byte81_sequence",   64'(seq81), 64'(8'h81));
    check("checker_line",      chk_line, 64'hAAAA_AAAA_AAAA_AAAA);
    check("probe_hits",        64'(probe_hits), 64'(NPROBE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
